// File: rtl/axi_riscv_lrsc_sched_pkg.sv
// Shared types for the LR/SC reservation-table scheduler.
//   src_e        : request sources, in round-robin order (WR, SC, LR).
//   state_e      : scheduler FSM states.
//   resv_entry_t : one reservation-table entry (valid + address granule).
//   next_src()   : round-robin successor of a source.
package axi_riscv_lrsc_sched_pkg;

    typedef enum logic [1:0] {
        SRC_WR = 2'd0,
        SRC_SC = 2'd1,
        SRC_LR = 2'd2
    } src_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SC_RSP = 1'b1
    } state_e;

    localparam int unsigned NUM_SRC = 3;

    // Granule field is sized for the widest supported address (64 bit,
    // GRANULE_LSB = 0). It holds addr[ADDR_WIDTH-1:GRANULE_LSB]
    // zero-extended; unused upper bits are constant zero.
    localparam int unsigned RESV_ADDR_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [RESV_ADDR_W-1:0] addr;
    } resv_entry_t;

    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_WR:  return SRC_SC;
            SRC_SC:  return SRC_LR;
            default: return SRC_WR;
        endcase
    endfunction

endpackage

// File: rtl/axi_riscv_lrsc_resv_table.sv
// Reservation table: one entry per identity, holding a valid bit and the
// reserved address granule.
//   clk_i, rst_i        : clock, synchronous active-high reset (clears table)
//   flush_i             : invalidate every entry at the next edge
//   set_*               : write entry[set_id] = {1, granule(set_addr)}
//   clr_id_*            : invalidate entry[clr_id]
//   clr_match_*         : invalidate every entry matching clr_match_addr
//   lookup_id/addr_i    : combinational query
//   lookup_ok_o         : entry[lookup_id] is valid and matches lookup_addr
module axi_riscv_lrsc_resv_table
    import axi_riscv_lrsc_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned GRANULE_LSB = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  set_en_i,
    input  logic [ID_WIDTH-1:0]   set_id_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_id_en_i,
    input  logic [ID_WIDTH-1:0]   clr_id_i,
    input  logic                  clr_match_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_match_addr_i,
    input  logic [ID_WIDTH-1:0]   lookup_id_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  lookup_ok_o
);

    localparam int unsigned NUM_ENTRIES = 2 ** ID_WIDTH;

    function automatic logic [RESV_ADDR_W-1:0] granule(input logic [ADDR_WIDTH-1:0] a);
        return RESV_ADDR_W'(a >> GRANULE_LSB);
    endfunction

    resv_entry_t              entries_q [NUM_ENTRIES];
    resv_entry_t              entries_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   match;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = entries_q[i].valid &&
                       (entries_q[i].addr == granule(clr_match_addr_i));
        end
    end

    assign lookup_ok_o = entries_q[lookup_id_i].valid &&
                         (entries_q[lookup_id_i].addr == granule(lookup_addr_i));

    // The scheduler grants at most one source per cycle, so set and clear
    // never target the same cycle; flush overrides everything.
    always_comb begin
        entries_d = entries_q;
        if (clr_match_en_i) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (match[i]) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end
        if (clr_id_en_i) begin
            entries_d[clr_id_i].valid = 1'b0;
        end
        if (set_en_i) begin
            entries_d[set_id_i].valid = 1'b1;
            entries_d[set_id_i].addr  = granule(set_addr_i);
        end
        if (flush_i) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/axi_riscv_lrsc_sched.sv
// LR/SC reservation-table scheduler. Serializes LR sets, SC checks and
// ordinary-write invalidations onto one reservation table with round-robin
// arbitration (WR, SC, LR), one grant per cycle, and returns SC results.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   flush_i                      : clear all reservations, block grants
//   lr_valid_i/lr_ready_o/...    : LR reservation set request
//   sc_valid_i/sc_ready_o/...    : SC check request
//   sc_rsp_valid_o/ready_i/ok_o  : SC result handshake
//   wr_valid_i/wr_ready_o/addr   : ordinary-write invalidation request
//   busy_o                       : SC result pending
module axi_riscv_lrsc_sched
    import axi_riscv_lrsc_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned GRANULE_LSB = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  lr_valid_i,
    output logic                  lr_ready_o,
    input  logic [ID_WIDTH-1:0]   lr_id_i,
    input  logic [ADDR_WIDTH-1:0] lr_addr_i,
    input  logic                  sc_valid_i,
    output logic                  sc_ready_o,
    input  logic [ID_WIDTH-1:0]   sc_id_i,
    input  logic [ADDR_WIDTH-1:0] sc_addr_i,
    output logic                  sc_rsp_valid_o,
    input  logic                  sc_rsp_ready_i,
    output logic                  sc_rsp_ok_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    output logic                  busy_o
);

    state_e               state_q, state_d;
    src_e                 rr_q, rr_d;
    logic                 rsp_ok_q, rsp_ok_d;

    logic [NUM_SRC-1:0]   req;
    logic                 grant_vld;
    src_e                 grant_src;
    src_e                 cand;
    logic                 lookup_ok;

    logic                 tbl_set_en;
    logic                 tbl_clr_id_en;
    logic                 tbl_clr_match_en;
    logic [ADDR_WIDTH-1:0] tbl_clr_match_addr;

    // Round-robin arbitration: walk the sources starting at rr_q.
    always_comb begin
        req          = '0;
        req[SRC_WR]  = wr_valid_i;
        req[SRC_SC]  = sc_valid_i;
        req[SRC_LR]  = lr_valid_i;
        grant_vld    = 1'b0;
        grant_src    = SRC_WR;
        cand         = rr_q;
        if ((state_q == IDLE) && !flush_i && !rst_i) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (!grant_vld && req[cand]) begin
                    grant_vld = 1'b1;
                    grant_src = cand;
                end
                cand = next_src(cand);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_q     <= SRC_WR;
            rsp_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            rsp_ok_q <= rsp_ok_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        rsp_ok_d = rsp_ok_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    rr_d = next_src(grant_src);
                    if (grant_src == SRC_SC) begin
                        state_d  = SC_RSP;
                        rsp_ok_d = lookup_ok;
                    end
                end
            end
            SC_RSP: begin
                if (sc_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and table controls
    always_comb begin
        lr_ready_o         = grant_vld && (grant_src == SRC_LR);
        sc_ready_o         = grant_vld && (grant_src == SRC_SC);
        wr_ready_o         = grant_vld && (grant_src == SRC_WR);
        sc_rsp_valid_o     = (state_q == SC_RSP);
        busy_o             = (state_q == SC_RSP);
        sc_rsp_ok_o        = rsp_ok_q;
        tbl_set_en         = lr_ready_o;
        tbl_clr_id_en      = sc_ready_o;
        // A successful SC also kills other reservations on the same granule.
        tbl_clr_match_en   = wr_ready_o || (sc_ready_o && lookup_ok);
        tbl_clr_match_addr = wr_ready_o ? wr_addr_i : sc_addr_i;
    end

    axi_riscv_lrsc_resv_table #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ID_WIDTH    (ID_WIDTH),
        .GRANULE_LSB (GRANULE_LSB)
    ) u_table (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .set_en_i         (tbl_set_en),
        .set_id_i         (lr_id_i),
        .set_addr_i       (lr_addr_i),
        .clr_id_en_i      (tbl_clr_id_en),
        .clr_id_i         (sc_id_i),
        .clr_match_en_i   (tbl_clr_match_en),
        .clr_match_addr_i (tbl_clr_match_addr),
        .lookup_id_i      (sc_id_i),
        .lookup_addr_i    (sc_addr_i),
        .lookup_ok_o      (lookup_ok)
    );

endmodule

// File: tb/tb_axi_riscv_lrsc_sched.sv
module tb_axi_riscv_lrsc_sched;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned GL = 3;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          lr_valid, lr_ready;
    logic [IW-1:0] lr_id;
    logic [AW-1:0] lr_addr;
    logic          sc_valid, sc_ready;
    logic [IW-1:0] sc_id;
    logic [AW-1:0] sc_addr;
    logic          sc_rsp_valid, sc_rsp_ready, sc_rsp_ok;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic          busy;

    always #5 clk = ~clk;

    axi_riscv_lrsc_sched #(
        .ADDR_WIDTH  (AW),
        .ID_WIDTH    (IW),
        .GRANULE_LSB (GL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .lr_valid_i     (lr_valid),
        .lr_ready_o     (lr_ready),
        .lr_id_i        (lr_id),
        .lr_addr_i      (lr_addr),
        .sc_valid_i     (sc_valid),
        .sc_ready_o     (sc_ready),
        .sc_id_i        (sc_id),
        .sc_addr_i      (sc_addr),
        .sc_rsp_valid_o (sc_rsp_valid),
        .sc_rsp_ready_i (sc_rsp_ready),
        .sc_rsp_ok_o    (sc_rsp_ok),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_addr_i      (wr_addr),
        .busy_o         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: reservations per identity, RR pointer as a source
    // index (0=WR, 1=SC, 2=LR), and the pending SC result.
    bit          m_valid [16];
    logic [63:0] m_gran  [16];
    int          m_rr;
    bit          m_in_rsp;
    bit          m_ok;
    int          g_src;   // source granted in the last cycle, -1 if none

    function automatic logic [63:0] gran(input logic [63:0] a);
        return a >> GL;
    endfunction

    task automatic m_clear_all();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_clear_match(input logic [63:0] a);
        for (int i = 0; i < 16; i++)
            if (m_valid[i] && m_gran[i] == gran(a)) m_valid[i] = 1'b0;
    endtask

    task automatic model_step();
        bit req [3];
        int w;
        bit ok;
        bit rsp_hs;
        req[0] = wr_valid;
        req[1] = sc_valid;
        req[2] = lr_valid;
        w = -1;
        if (!rst && !m_in_rsp && !flush)
            for (int k = 0; k < 3; k++)
                if (w < 0 && req[(m_rr + k) % 3]) w = (m_rr + k) % 3;

        check_eq("wr_ready", 64'(wr_ready), 64'(w == 0));
        check_eq("sc_ready", 64'(sc_ready), 64'(w == 1));
        check_eq("lr_ready", 64'(lr_ready), 64'(w == 2));
        check_eq("sc_rsp_valid", 64'(sc_rsp_valid), 64'(m_in_rsp));
        check_eq("busy", 64'(busy), 64'(m_in_rsp));
        if (m_in_rsp) check_eq("sc_rsp_ok", 64'(sc_rsp_ok), 64'(m_ok));

        g_src  = w;
        rsp_hs = m_in_rsp && sc_rsp_ready;
        if (rst) begin
            m_clear_all();
            m_rr = 0; m_in_rsp = 0; m_ok = 0;
        end else begin
            if (flush) m_clear_all();
            case (w)
                0: m_clear_match(wr_addr);
                1: begin
                    ok = m_valid[sc_id] && (m_gran[sc_id] == gran(sc_addr));
                    m_valid[sc_id] = 1'b0;
                    if (ok) m_clear_match(sc_addr);
                    m_in_rsp = 1'b1;
                    m_ok     = ok;
                end
                2: begin
                    m_valid[lr_id] = 1'b1;
                    m_gran[lr_id]  = gran(lr_addr);
                end
                default: ;
            endcase
            if (w >= 0) m_rr = (w + 1) % 3;
            if (rsp_hs) m_in_rsp = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_granted();
        case (g_src)
            0: wr_valid = 1'b0;
            1: sc_valid = 1'b0;
            2: lr_valid = 1'b0;
            default: ;
        endcase
    endtask

    task automatic wait_grant(input int src, input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            cycle();
            if (g_src == src) got = 1'b1;
        end
        check_eq(tag, 64'(got), 64'd1);
    endtask

    task automatic do_lr(input logic [IW-1:0] id, input logic [AW-1:0] a);
        lr_id = id; lr_addr = a; lr_valid = 1'b1;
        wait_grant(2, "lr_grant");
        lr_valid = 1'b0;
    endtask

    task automatic do_wr(input logic [AW-1:0] a);
        wr_addr = a; wr_valid = 1'b1;
        wait_grant(0, "wr_grant");
        wr_valid = 1'b0;
    endtask

    task automatic do_sc(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input bit exp_ok, input string tag);
        sc_rsp_ready = 1'b0;
        sc_id = id; sc_addr = a; sc_valid = 1'b1;
        wait_grant(1, "sc_grant");
        sc_valid = 1'b0;
        check_eq({tag, "_valid"}, 64'(sc_rsp_valid), 64'd1);
        check_eq(tag, 64'(sc_rsp_ok), 64'(exp_ok));
        sc_rsp_ready = 1'b1;
        cycle();
        sc_rsp_ready = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int n = 0; n < bound; n++) begin
            if (!lr_valid && !sc_valid && !wr_valid && !m_in_rsp) break;
            sc_rsp_ready = 1'b1;
            cycle();
            drop_granted();
        end
        sc_rsp_ready = 1'b0;
        check_eq("drain_done", 64'(lr_valid || sc_valid || wr_valid || m_in_rsp), 64'd0);
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] bases [4];
        bases[0] = 64'h40; bases[1] = 64'h48; bases[2] = 64'h1000; bases[3] = 64'h2000;
        return bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 15));
    endfunction

    initial begin
        int order [$];
        logic held_ok;

        rst = 1'b1; flush = 1'b0; sc_rsp_ready = 1'b0;
        lr_valid = 1'b1; sc_valid = 1'b1; wr_valid = 1'b1;
        lr_id = '0; sc_id = '0; lr_addr = '0; sc_addr = '0; wr_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_lr_ready", 64'(lr_ready), 64'd0);
        check_eq("rst_sc_ready", 64'(sc_ready), 64'd0);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(sc_rsp_valid), 64'd0);
        check_eq("rst_rsp_ok", 64'(sc_rsp_ok), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        m_clear_all(); m_rr = 0; m_in_rsp = 0; m_ok = 0; g_src = -1;
        lr_valid = 1'b0; sc_valid = 1'b0; wr_valid = 1'b0;
        rst = 1'b0;

        // Same-granule SC succeeds once
        do_lr(4'd2, 64'h1000);
        do_sc(4'd2, 64'h1004, 1'b1, "sc_same_granule");
        do_sc(4'd2, 64'h1000, 1'b0, "sc_consumed");

        // Write invalidation
        do_lr(4'd1, 64'h2000);
        do_wr(64'h2000);
        do_sc(4'd1, 64'h2000, 1'b0, "sc_after_wr_hit");
        do_lr(4'd1, 64'h2000);
        do_wr(64'h3000);
        do_sc(4'd1, 64'h2000, 1'b1, "sc_after_wr_miss");

        // Successful SC clears other IDs' reservations on the granule
        do_lr(4'd0, 64'h40);
        do_lr(4'd3, 64'h40);
        do_sc(4'd0, 64'h40, 1'b1, "sc_id0");
        do_sc(4'd3, 64'h40, 1'b0, "sc_id3_killed");

        // Round-robin order from reset pointer
        rst = 1'b1; cycle(); rst = 1'b0;
        wr_addr = 64'hF000; sc_id = 4'd9; sc_addr = 64'hE000;
        lr_id = 4'd10; lr_addr = 64'hD000;
        wr_valid = 1'b1; sc_valid = 1'b1; lr_valid = 1'b1; sc_rsp_ready = 1'b1;
        for (int n = 0; n < 20 && order.size() < 3; n++) begin
            cycle();
            if (g_src >= 0) order.push_back(g_src);
            drop_granted();
        end
        check_eq("rr_count", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            check_eq("rr_first", 64'(order[0]), 64'd0);
            check_eq("rr_second", 64'(order[1]), 64'd1);
            check_eq("rr_third", 64'(order[2]), 64'd2);
        end
        wr_valid = 1'b1; sc_valid = 1'b1; lr_valid = 1'b1;
        cycle();
        check_eq("rr_wrap_wr", 64'(g_src), 64'd0);
        drop_granted();
        drain(40);

        // Stalled SC response
        do_lr(4'd9, 64'h9000);
        sc_rsp_ready = 1'b0;
        sc_id = 4'd9; sc_addr = 64'h9000; sc_valid = 1'b1;
        wait_grant(1, "stall_sc_grant");
        sc_valid = 1'b0;
        held_ok = sc_rsp_ok;
        check_eq("stall_ok_first", 64'(held_ok), 64'd1);
        lr_id = 4'd3; lr_addr = 64'h3000; lr_valid = 1'b1;
        wr_addr = 64'hA000; wr_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check_eq("stall_ok_stable", 64'(sc_rsp_ok), 64'(held_ok));
            check_eq("stall_valid", 64'(sc_rsp_valid), 64'd1);
        end
        drain(20);

        // Flush with LR pending
        do_lr(4'd6, 64'h6000);
        lr_id = 4'd5; lr_addr = 64'h5000; lr_valid = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_grant(2, "post_flush_lr");
        lr_valid = 1'b0;
        do_sc(4'd6, 64'h6000, 1'b0, "sc_after_flush");
        do_sc(4'd5, 64'h5000, 1'b1, "sc_lr_after_flush");

        // Reset while SC result pending
        do_lr(4'd7, 64'h7000);
        do_lr(4'd8, 64'h8000);
        sc_id = 4'd7; sc_addr = 64'h7000; sc_valid = 1'b1;
        wait_grant(1, "rst_sc_grant");
        sc_valid = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("rst_mid_rsp_valid", 64'(sc_rsp_valid), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        do_sc(4'd8, 64'h8000, 1'b0, "sc_after_rst");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!lr_valid && $urandom_range(0, 2) == 0) begin
                lr_id = IW'($urandom_range(0, 5)); lr_addr = rnd_addr(); lr_valid = 1'b1;
            end
            if (!sc_valid && $urandom_range(0, 2) == 0) begin
                sc_id = IW'($urandom_range(0, 5)); sc_addr = rnd_addr(); sc_valid = 1'b1;
            end
            if (!wr_valid && $urandom_range(0, 4) == 0) begin
                wr_addr = rnd_addr(); wr_valid = 1'b1;
            end
            flush        = ($urandom_range(0, 31) == 0);
            sc_rsp_ready = ($urandom_range(0, 1) == 1);
            cycle();
            drop_granted();
        end
        flush = 1'b0;
        drain(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
